coco_uart_tx: RTL and testbench
===============================

Name: coco_uart_tx

Overview:
- Buffered asynchronous-serial transmitter; the transmit end of the serial link whose receive side is the `uart_din` line.
- Host side pushes bytes into an internal FIFO. The block serialises them as 8-bit LSB-first frames on `txd`, with optional parity and 1 or 2 stop bits.
- Lives beside the CPU/PIA fabric in the same 50 MHz system-clock domain. Used for the bit-banger/serial loopback and for debug output.

Parameters:
- CLKS_PER_BIT, 434, system clocks per bit cell (50 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk, input, 1, system clock (50 MHz).
- reset, input, 1, synchronous, active-low reset.
- tx_enable, input, 1, when high, frames may start.
- wr_en, input, 1, push request.
- wr_data, input, 8, byte to push.
- full, output, 1, FIFO holds FIFO_DEPTH entries.
- empty, output, 1, FIFO holds 0 entries.
- level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
- overflow, output, 1, one-cycle pulse when wr_en arrives while full.
- busy, output, 1, high while a frame is on the line.
- txd, output, 1, serial line; idle high.

Behaviour:
- Reset (reset low at a clk edge) forces:
  - txd = 1, busy = 0, full = 0, empty = 1, level = 0, overflow = 0;
  - FIFO pointers = 0, FSM = IDLE, baud counter = 0.
- Reset mid-frame aborts the frame. txd returns high on the cycle after the reset edge. FIFO contents are discarded.
- Push:
  - wr_en with full = 0 stores wr_data. level increments on the next edge.
  - wr_en with full = 1 drops the byte and pulses overflow high for exactly one cycle.
  - full is computed from the registered level only. A same-cycle pop does not make room for a write while full.
- Simultaneous push and pop when not full: level is unchanged and both operations complete.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If tx_enable = 1 and empty = 0: pop the head byte into the shift register, load bit_idx = 0, load the baud counter, go to START.
  - txd goes low on the cycle after the pop.
- Bit-cell timing: every state holds txd for exactly CLKS_PER_BIT cycles. The baud counter counts CLKS_PER_BIT-1 down to 0; the state advances on 0.
- START: txd = 0. Then go to DATA.
- DATA:
  - txd = shift[0]. Shift right at the end of each cell.
  - After the cell with bit_idx = 7: go to PARITY if PARITY != 0, else to STOP.
- PARITY: txd = XOR of the 8 data bits, inverted for odd parity. Then go to STOP.
- STOP:
  - txd = 1 for STOP_BITS cells.
  - At the end of the last cell: if tx_enable = 1 and empty = 0, pop and go directly to START, so there is no idle gap. Otherwise go to IDLE.
- Frame length is exactly (1 + 8 + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy = 1 in every state except IDLE.
- Latency: wr_en at cycle N into an empty FIFO with the FSM in IDLE and tx_enable high:
  - empty falls at N+1;
  - pop occurs at N+1;
  - txd falls at N+2.
- tx_enable deasserted mid-frame: the current frame completes, then no new frame starts. Bytes remain queued.
- tx_enable changes are sampled only in IDLE and at the end of STOP.
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. level distinguishes full from empty.
- txd is driven from a register, so it is glitch-free.

Decomposition:
- Shared package `coco_uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity codes PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - function `frame_bits(parity, stop_bits)`.
- One sub-module: `uart_fifo`, a synchronous FIFO with wr_en/wr_data/rd_en/rd_data/full/empty/level and first-word-fall-through read.
- The baud counter and FSM stay in the top module.

Test Plan:
- Reset, then write 8'h55 with CLKS_PER_BIT = 4 and default params:
  - txd falls 2 cycles after wr_en;
  - observed sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles;
  - busy high for 40 cycles, then returns to 0.
- Write 8'hA5, 8'h3C back-to-back:
  - the two frames are contiguous; the second start bit immediately follows the first stop bit;
  - empty rises on the second pop;
  - total busy time is 80 cycles.
- PARITY = 2, STOP_BITS = 2, byte 8'h07: parity bit = 0 (three ones, odd parity) followed by two 1-cells; frame is 12 cells long.
- Fill FIFO_DEPTH = 16 while tx_enable = 0, then write a 17th byte:
  - full = 1 and level = 16;
  - overflow pulses for 1 cycle;
  - the 17th byte is never transmitted;
  - raising tx_enable sends exactly the 16 bytes in order.
- Assert reset during the DATA state of the 3rd queued byte:
  - txd = 1 and empty = 1 on the next cycle;
  - no further frames are sent after reset is released.
- Drop tx_enable during the DATA state of the first of 3 queued bytes:
  - that frame completes;
  - level stays at 2 and the line stays idle;
  - restoring tx_enable resumes transmission.

Source files
------------

// File: rtl/coco_uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package coco_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Baud counter width; covers the full CLKS_PER_BIT range.
   localparam int CNT_W = 16;

   // Number of bit cells in one frame: start + 8 data + optional parity + stop bits.
   function automatic int frame_bits(input int parity, input int stop_bits);
      return 1 + 8 + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/coco_uart_tx_if.sv
// Host-side bundle of the UART transmitter: push port, FIFO status, line.
interface coco_uart_tx_if #(
   parameter int FIFO_DEPTH = 16
) ();
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             tx_enable;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             full;
   logic             empty;
   logic [LVL_W-1:0] level;
   logic             overflow;
   logic             busy;
   logic             txd;

   modport master (
      output tx_enable, wr_en, wr_data,
      input  full, empty, level, overflow, busy, txd
   );

   modport slave (
      input  tx_enable, wr_en, wr_data,
      output full, empty, level, overflow, busy, txd
   );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data always shows the head entry.
module uart_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_wr;
   logic             do_rd;

   // Full/empty come from the registered level only, so a same-cycle pop
   // never frees a slot for a write.
   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
      level_d  = level_q;
      if (do_wr && !do_rd) begin
         level_d = level_q + LVL_W'(1);
      end else if (!do_wr && do_rd) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   // Pointer/level registers; storage contents are left stale on reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage write port.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/coco_uart_tx.sv
// Buffered UART transmitter: FIFO in front of an 8-bit LSB-first serialiser.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | line high, waiting for tx_enable and a queued byte
//   ST_START  | start cell, txd low
//   ST_DATA   | data cells, txd = shift_q[0], LSB first
//   ST_PARITY | parity cell (only when PARITY != PAR_NONE)
//   ST_STOP   | STOP_BITS high cells; may chain straight into ST_START
module coco_uart_tx import coco_uart_pkg::*; #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
) (
   input logic           clk,
   input logic           reset,
   coco_uart_tx_if.slave bus
);

   localparam int               LVL_W      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic             PAR_INV    = (PARITY == PAR_ODD);
   localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             stop_idx_q, stop_idx_d;
   logic             par_q, par_d;
   logic             txd_q, txd_d;
   logic             ovf_q, ovf_d;

   logic             rd_en;
   logic [7:0]       rd_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LVL_W-1:0] fifo_level;
   logic             pop_ok;
   logic             tick;

   uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.wr_en),
      .wr_data (bus.wr_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign bus.full     = fifo_full;
   assign bus.empty    = fifo_empty;
   assign bus.level    = fifo_level;
   assign bus.overflow = ovf_q;
   assign bus.txd      = txd_q;
   assign bus.busy     = (state_q != ST_IDLE);

   assign pop_ok = bus.tx_enable && !fifo_empty;
   assign tick   = (cnt_q == '0);

   // Next-state, baud counter and line value; txd_d follows the next state so
   // the registered line lines up with the registered state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      par_d      = par_q;
      rd_en      = 1'b0;
      ovf_d      = bus.wr_en && fifo_full;

      if (state_q != ST_IDLE) begin
         cnt_d = tick ? CNT_RELOAD : cnt_q - CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (pop_ok) begin
               rd_en     = 1'b1;
               state_d   = ST_START;
               cnt_d     = CNT_RELOAD;
               shift_d   = rd_data;
               bit_idx_d = '0;
               par_d     = (^rd_data) ^ PAR_INV;
            end
         end
         ST_START: begin
            if (tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  if (PARITY != PAR_NONE) begin
                     state_d = ST_PARITY;
                  end else begin
                     state_d    = ST_STOP;
                     stop_idx_d = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d    = ST_STOP;
               stop_idx_d = 1'b0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (stop_idx_q != STOP_LAST) begin
                  stop_idx_d = 1'b1;
               end else if (pop_ok) begin
                  // Back-to-back frame: no idle gap between stop and start.
                  rd_en     = 1'b1;
                  state_d   = ST_START;
                  shift_d   = rd_data;
                  bit_idx_d = '0;
                  par_d     = (^rd_data) ^ PAR_INV;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
         ST_PARITY: txd_d = par_d;
         default:   txd_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset aborts any frame and idles the line.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         par_q      <= 1'b0;
         txd_q      <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         par_q      <= par_d;
         txd_q      <= txd_d;
         ovf_q      <= ovf_d;
      end
   end

endmodule

// File: tb/tb_coco_uart_tx.sv
// Bench for coco_uart_tx: two instances (8N1 and 8O2), both at 4 clocks per bit.
module tb_coco_uart_tx;
   import coco_uart_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 16;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] line;   // bit i = expected txd during cell i
      int          ncells;
   } frame_vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   coco_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
   coco_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

   coco_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .PARITY       (PAR_NONE),
      .STOP_BITS    (1)
   ) dut0 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus0)
   );

   coco_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .PARITY       (PAR_ODD),
      .STOP_BITS    (2)
   ) dut1 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic txd_of(input int d);
      return (d == 0) ? bus0.txd : bus1.txd;
   endfunction

   function automatic logic busy_of(input int d);
      return (d == 0) ? bus0.busy : bus1.busy;
   endfunction

   task automatic push(input int d, input logic [7:0] b);
      if (d == 0) begin
         bus0.wr_en   = 1'b1;
         bus0.wr_data = b;
      end else begin
         bus1.wr_en   = 1'b1;
         bus1.wr_data = b;
      end
      step();
      bus0.wr_en = 1'b0;
      bus1.wr_en = 1'b0;
   endtask

   task automatic apply_reset();
      bus0.tx_enable = 1'b0;
      bus0.wr_en     = 1'b0;
      bus0.wr_data   = 8'h00;
      bus1.tx_enable = 1'b0;
      bus1.wr_en     = 1'b0;
      bus1.wr_data   = 8'h00;
      rst_n = 1'b0;
      step();
      step();
      check("reset txd",      32'(bus0.txd),      32'd1);
      check("reset busy",     32'(bus0.busy),     32'd0);
      check("reset full",     32'(bus0.full),     32'd0);
      check("reset empty",    32'(bus0.empty),    32'd1);
      check("reset level",    32'(bus0.level),    32'd0);
      check("reset overflow", 32'(bus0.overflow), 32'd0);
      rst_n = 1'b1;
   endtask

   // Called on the first sample of a frame (txd already low); returns on the
   // first sample after the frame's last cell.
   task automatic check_frame(input int d, input string nm, input logic [15:0] line,
                              input int ncells, input int drop_at);
      int          bcnt;
      logic [15:0] sh;
      bcnt = 0;
      for (int k = 0; k < ncells * CPB; k++) begin
         if (k == drop_at) bus0.tx_enable = 1'b0;
         sh = line >> (k / CPB);
         check({nm, " txd"}, 32'(txd_of(d)), 32'(sh[0]));
         if (busy_of(d)) bcnt++;
         step();
      end
      check({nm, " busy cycles"}, 32'(bcnt), 32'(ncells * CPB));
   endtask

   frame_vec_t vec0[5];
   frame_vec_t vec1[2];

   initial begin
      int          ov;
      int          lows;
      logic [7:0]  b;

      vec0[0] = '{data: 8'h55, line: 16'h02AA, ncells: frame_bits(PAR_NONE, 1)};
      vec0[1] = '{data: 8'h00, line: 16'h0200, ncells: frame_bits(PAR_NONE, 1)};
      vec0[2] = '{data: 8'hFF, line: 16'h03FE, ncells: frame_bits(PAR_NONE, 1)};
      vec0[3] = '{data: 8'h01, line: 16'h0202, ncells: frame_bits(PAR_NONE, 1)};
      vec0[4] = '{data: 8'h80, line: 16'h0300, ncells: frame_bits(PAR_NONE, 1)};
      vec1[0] = '{data: 8'h07, line: 16'h0C0E, ncells: 12};
      vec1[1] = '{data: 8'h03, line: 16'h0E06, ncells: 12};

      bus0.tx_enable = 1'b0;
      bus0.wr_en     = 1'b0;
      bus0.wr_data   = 8'h00;
      bus1.tx_enable = 1'b0;
      bus1.wr_en     = 1'b0;
      bus1.wr_data   = 8'h00;

      // Single frames, 8N1: txd falls two cycles after wr_en.
      for (int i = 0; i < 5; i++) begin
         apply_reset();
         bus0.tx_enable = 1'b1;
         push(0, vec0[i].data);
         check("pre-pop txd",   32'(bus0.txd),   32'd1);
         check("pre-pop empty", 32'(bus0.empty), 32'd0);
         check("pre-pop level", 32'(bus0.level), 32'd1);
         step();
         check_frame(0, "8N1 frame", vec0[i].line, vec0[i].ncells, -1);
         check("post-frame busy",  32'(bus0.busy),  32'd0);
         check("post-frame txd",   32'(bus0.txd),   32'd1);
         check("post-frame empty", 32'(bus0.empty), 32'd1);
      end

      // Single frames, 8O2.
      for (int i = 0; i < 2; i++) begin
         apply_reset();
         bus1.tx_enable = 1'b1;
         push(1, vec1[i].data);
         step();
         check_frame(1, "8O2 frame", vec1[i].line, vec1[i].ncells, -1);
         check("8O2 post busy", 32'(bus1.busy), 32'd0);
         check("8O2 post txd",  32'(bus1.txd),  32'd1);
      end

      // Back-to-back: second start cell directly follows the first stop cell.
      apply_reset();
      bus0.tx_enable = 1'b1;
      push(0, 8'hA5);
      push(0, 8'h3C);
      check("b2b level after 2nd push", 32'(bus0.level), 32'd1);
      check("b2b empty after 2nd push", 32'(bus0.empty), 32'd0);
      check_frame(0, "b2b first", 16'h034A, 10, -1);
      check("b2b empty at 2nd pop", 32'(bus0.empty), 32'd1);
      check_frame(0, "b2b second", 16'h0278, 10, -1);
      check("b2b final busy", 32'(bus0.busy), 32'd0);

      // Fill with tx_enable low, overflow on the 17th byte, then drain in order.
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         push(0, 8'h10 + 8'(i));
         check("fill level", 32'(bus0.level), 32'(i + 1));
      end
      check("fill full",  32'(bus0.full),  32'd1);
      check("fill empty", 32'(bus0.empty), 32'd0);
      bus0.wr_en   = 1'b1;
      bus0.wr_data = 8'hEE;
      step();
      bus0.wr_en = 1'b0;
      ov = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus0.overflow) ov++;
         step();
      end
      check("overflow pulse count", 32'(ov), 32'd1);
      check("level after overflow", 32'(bus0.level), 32'd16);
      check("full after overflow",  32'(bus0.full),  32'd1);
      check("no tx while disabled", 32'(bus0.busy),  32'd0);
      bus0.tx_enable = 1'b1;
      step();
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'h10 + 8'(i);
         check_frame(0, "drain order", {6'b0, 1'b1, b, 1'b0}, 10, -1);
      end
      check("drain busy",  32'(bus0.busy),  32'd0);
      check("drain empty", 32'(bus0.empty), 32'd1);
      lows = 0;
      for (int i = 0; i < 12; i++) begin
         if (!bus0.txd || bus0.busy) lows++;
         step();
      end
      check("dropped byte not sent", 32'(lows), 32'd0);

      // Reset during DATA of the third queued byte, with a fourth still queued.
      apply_reset();
      bus0.tx_enable = 1'b1;
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      push(0, 8'h44);
      for (int i = 0; i < 92; i++) step();
      check("3rd frame data bit2", 32'(bus0.txd),   32'd0);
      check("3rd frame busy",      32'(bus0.busy),  32'd1);
      check("3rd frame level",     32'(bus0.level), 32'd1);
      rst_n = 1'b0;
      step();
      check("mid-frame reset txd",   32'(bus0.txd),   32'd1);
      check("mid-frame reset empty", 32'(bus0.empty), 32'd1);
      check("mid-frame reset busy",  32'(bus0.busy),  32'd0);
      check("mid-frame reset level", 32'(bus0.level), 32'd0);
      rst_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         if (!bus0.txd || bus0.busy) lows++;
         step();
      end
      check("no frames after reset", 32'(lows), 32'd0);

      // tx_enable dropped mid-frame: frame completes, rest stays queued.
      apply_reset();
      push(0, 8'h5A);
      push(0, 8'hC3);
      push(0, 8'h96);
      bus0.tx_enable = 1'b1;
      step();
      check_frame(0, "drop frame", 16'h02B4, 10, 10);
      check("drop idle busy",  32'(bus0.busy),  32'd0);
      check("drop idle level", 32'(bus0.level), 32'd2);
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus0.txd || bus0.busy) lows++;
         step();
      end
      check("drop line idle", 32'(lows), 32'd0);
      check("drop level held", 32'(bus0.level), 32'd2);
      bus0.tx_enable = 1'b1;
      step();
      check_frame(0, "resume first", 16'h0386, 10, -1);
      check_frame(0, "resume second", 16'h032C, 10, -1);
      check("resume busy",  32'(bus0.busy),  32'd0);
      check("resume empty", 32'(bus0.empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
